ddr_port_arbiter: RTL and testbench
===================================

DDR_PORT_ARBITER -- requirements
Module: ddr_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 27, giving the byte-address width of all arw_addr buses.
REQ-002 SHALL have parameter ID_WIDTH, default 1, giving the width of m_arw_id.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have p0_arw_valid/p0_arw_ready, input/output, 1/1: port 0 (CPU, read+write) command handshake.
REQ-006 SHALL have p0_arw_addr/p0_arw_len/p0_arw_write, input, ADDR_W/8/1: port 0 command payload.
REQ-007 SHALL have p0_wvalid/p0_wready/p0_wlast, input/output/input, 1: port 0 write-data handshake.
REQ-008 SHALL have p0_wdata/p0_wstrb, input, 64/8: port 0 write payload.
REQ-009 SHALL have p0_bvalid/p0_bready, output/input, 1: port 0 write response.
REQ-010 SHALL have p0_rvalid/p0_rlast/p0_rready, output/output/input, 1: port 0 read data.
REQ-011 SHALL have p1_arw_valid/p1_arw_ready, input/output, 1: port 1 (video, read-only) command handshake.
REQ-012 SHALL have p1_arw_addr/p1_arw_len, input, ADDR_W/8: port 1 command payload; writes are implied 0.
REQ-013 SHALL have p1_rvalid/p1_rlast/p1_rready, output/output/input, 1: port 1 read data.
REQ-014 SHALL have rdata, output, 64: shared read data, driven combinationally from m_rdata.
REQ-015 SHALL have m_arw_valid/m_arw_ready, output/input, 1: command handshake to the DDR controller.
REQ-016 SHALL have m_arw_addr/m_arw_len/m_arw_write/m_arw_id, output, ADDR_W/8/1/ID_WIDTH: registered command payload.
REQ-017 SHALL have m_wvalid/m_wready/m_wlast/m_wdata/m_wstrb, out/in/out/out/out, 1/1/1/64/8: controller write channel.
REQ-018 SHALL have m_bvalid/m_bready and m_rvalid/m_rready/m_rlast/m_rdata, in/out and in/out/in/in, 1/1 and 1/1/1/64: controller response channels.

Function
REQ-019 SHALL run FSM states IDLE, CMD, WDATA, WRESP, RDATA, processing exactly one transaction at a time.
REQ-020 IDLE: when any pN_arw_valid is high, SHALL pulse the winner's pN_arw_ready for one cycle, register its payload and grant, and go to CMD.
REQ-021 Arbitration SHALL be round-robin on registered last_grant: if both ports request, the port not in last_grant wins; a lone requester always wins.
REQ-022 The captured payload SHALL drive m_arw_addr and m_arw_len; m_arw_write SHALL be p0_arw_write for port 0 and 0 for port 1; m_arw_id SHALL be the zero-extended grant index.
REQ-023 CMD: SHALL hold m_arw_valid high and the payload stable until m_arw_ready, then go to WDATA if the command is a write, else RDATA.
REQ-024 WDATA: SHALL connect m_wvalid=p0_wvalid, p0_wready=m_wready, and pass m_wdata/m_wstrb/m_wlast through combinationally.
REQ-025 WDATA SHALL go to WRESP on m_wvalid&m_wready&m_wlast.
REQ-026 WRESP: SHALL drive p0_bvalid=m_bvalid and m_bready=p0_bready, and go to IDLE on that handshake.
REQ-027 RDATA: SHALL drive pG_rvalid=m_rvalid and pG_rlast=m_rlast for the granted port G only, and m_rready=pG_rready.
REQ-028 RDATA SHALL go to IDLE on m_rvalid&m_rlast; requesters SHALL hold rready high during reads because the controller ignores backpressure.
REQ-029 The non-granted port SHALL see rvalid=0, bvalid=0, wready=0 and arw_ready=0 in every state.
REQ-030 pN_arw_ready SHALL be 0 outside IDLE.
REQ-031 IDLE SHALL always last at least one cycle between transactions.
REQ-032 When requests arrive in back-to-back cycles, the minimum command-to-command gap SHALL be the transaction duration plus 1 cycle.
REQ-033 last_grant SHALL update only on capture in IDLE.

Reset
REQ-034 On reset, including mid-transaction, SHALL enter IDLE with last_grant=1 (port 0 wins the first tie).
REQ-035 During reset, all valid, ready and last outputs SHALL be 0, and the captured payload SHALL be 0.
REQ-036 After reset, no partial burst SHALL resume; the DDR controller shares the same reset.

Verification
REQ-037 Port 0 only, write addr 0x100, len 1 (4 beats, wlast on 4th) -> m_arw_write=1, m_arw_addr=0x100, 4 W beats, p0_bvalid mirrors m_bvalid, FSM back in IDLE.
REQ-038 Both ports request reads in the same cycle after reset -> port 0 granted first; port 1 granted at the next IDLE; p1_rvalid=0 throughout the port 0 burst.
REQ-039 Port 1 holds arw_valid continuously while port 0 re-requests on every IDLE -> grants alternate 0,1,0,1.
REQ-040 m_arw_ready held low for 5 cycles in CMD -> m_arw_valid and payload remain stable; no arw_ready pulse to either port.
REQ-041 Reset asserted during RDATA of a port 1 burst -> next cycle all outputs 0, state IDLE; a fresh port 1 read then completes normally with p1_rlast on its final beat.

Source files
------------

// File: rtl/ddr_port_arbiter.sv
// Two-port command arbiter in front of a single DDR controller.
// Port 0 (CPU) issues reads and writes, port 1 (video) issues reads only.
// Exactly one transaction is in flight; ports alternate round-robin on ties.
module ddr_port_arbiter #(
    parameter int ADDR_W   = 27,
    parameter int ID_WIDTH = 1
) (
    input  logic                clk,
    input  logic                reset,

    // port 0: CPU, read + write
    input  logic                p0_arw_valid,
    output logic                p0_arw_ready,
    input  logic [ADDR_W-1:0]   p0_arw_addr,
    input  logic [7:0]          p0_arw_len,
    input  logic                p0_arw_write,
    input  logic                p0_wvalid,
    output logic                p0_wready,
    input  logic                p0_wlast,
    input  logic [63:0]         p0_wdata,
    input  logic [7:0]          p0_wstrb,
    output logic                p0_bvalid,
    input  logic                p0_bready,
    output logic                p0_rvalid,
    output logic                p0_rlast,
    input  logic                p0_rready,

    // port 1: video, read only
    input  logic                p1_arw_valid,
    output logic                p1_arw_ready,
    input  logic [ADDR_W-1:0]   p1_arw_addr,
    input  logic [7:0]          p1_arw_len,
    output logic                p1_rvalid,
    output logic                p1_rlast,
    input  logic                p1_rready,

    // shared read data
    output logic [63:0]         rdata,

    // DDR controller side
    output logic                m_arw_valid,
    input  logic                m_arw_ready,
    output logic [ADDR_W-1:0]   m_arw_addr,
    output logic [7:0]          m_arw_len,
    output logic                m_arw_write,
    output logic [ID_WIDTH-1:0] m_arw_id,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic                m_wlast,
    output logic [63:0]         m_wdata,
    output logic [7:0]          m_wstrb,
    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic                m_rlast,
    input  logic [63:0]         m_rdata
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CMD   = 3'd1;
    localparam logic [2:0] WDATA = 3'd2;
    localparam logic [2:0] WRESP = 3'd3;
    localparam logic [2:0] RDATA = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic              write_q, write_d;

    // Every handshake output is qualified with live so that all valid/ready/last
    // outputs read 0 while reset is held, even before the state flop clears.
    logic live;
    logic in_idle, in_cmd, in_wdata, in_wresp, in_rdata;
    logic any_req;
    logic winner;

    logic [1:0] arw_ready_vec;
    logic [1:0] rvalid_vec;
    logic [1:0] rlast_vec;
    logic [1:0] rready_vec;

    assign live     = ~reset;
    assign in_idle  = live && (state_q == IDLE);
    assign in_cmd   = live && (state_q == CMD);
    assign in_wdata = live && (state_q == WDATA);
    assign in_wresp = live && (state_q == WRESP);
    assign in_rdata = live && (state_q == RDATA);
    assign any_req  = p0_arw_valid || p1_arw_valid;

    // Round-robin pick: on a tie the port that did not win last time goes first.
    always_comb begin
        winner = 1'b0;
        if (p0_arw_valid && p1_arw_valid) begin
            winner = ~last_grant_q;
        end else if (p1_arw_valid) begin
            winner = 1'b1;
        end
    end

    assign rready_vec = {p1_rready, p0_rready};

    // Per-port fan-out: only the granted port ever sees ready/valid/last.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign arw_ready_vec[gi] = in_idle && any_req && (winner == 1'(gi));
        assign rvalid_vec[gi]    = in_rdata && (grant_q == 1'(gi)) && m_rvalid;
        assign rlast_vec[gi]     = in_rdata && (grant_q == 1'(gi)) && m_rlast;
    end

    assign p0_arw_ready = arw_ready_vec[0];
    assign p1_arw_ready = arw_ready_vec[1];
    assign p0_rvalid    = rvalid_vec[0];
    assign p1_rvalid    = rvalid_vec[1];
    assign p0_rlast     = rlast_vec[0];
    assign p1_rlast     = rlast_vec[1];
    assign m_rready     = in_rdata && rready_vec[grant_q];
    assign rdata        = m_rdata;

    // Only port 0 can be granted a write, but the grant check keeps port 1 isolated.
    assign m_wvalid  = in_wdata && !grant_q && p0_wvalid;
    assign p0_wready = in_wdata && !grant_q && m_wready;
    assign m_wlast   = in_wdata && p0_wlast;
    assign m_wdata   = p0_wdata;
    assign m_wstrb   = p0_wstrb;

    assign p0_bvalid = in_wresp && !grant_q && m_bvalid;
    assign m_bready  = in_wresp && p0_bready;

    assign m_arw_valid = in_cmd;
    assign m_arw_addr  = addr_q;
    assign m_arw_len   = len_q;
    assign m_arw_write = write_q;
    assign m_arw_id    = ID_WIDTH'(grant_q);

    // Next-state and capture logic for the single-transaction sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        len_d        = len_q;
        write_d      = write_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d      = CMD;
                    grant_d      = winner;
                    last_grant_d = winner;
                    addr_d       = winner ? p1_arw_addr : p0_arw_addr;
                    len_d        = winner ? p1_arw_len  : p0_arw_len;
                    write_d      = winner ? 1'b0        : p0_arw_write;
                end
            end
            CMD: begin
                if (m_arw_ready) begin
                    state_d = write_q ? WDATA : RDATA;
                end
            end
            WDATA: begin
                if (m_wvalid && m_wready && m_wlast) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                if (m_bvalid && m_bready) begin
                    state_d = IDLE;
                end
            end
            RDATA: begin
                // The controller ignores backpressure, so the burst ends on rlast alone.
                if (m_rvalid && m_rlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured payload registers; reset abandons any partial burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            write_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            write_q      <= write_d;
        end
    end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Randomized bench for ddr_port_arbiter: two port drivers, a DDR controller model
// and a negedge monitor that checks commands, data and grants against queues.
`timescale 1ns/1ps
module tb_ddr_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_arw_valid, p0_arw_ready, p0_arw_write;
    logic [26:0] p0_arw_addr;
    logic [7:0]  p0_arw_len;
    logic        p0_wvalid, p0_wready, p0_wlast;
    logic [63:0] p0_wdata;
    logic [7:0]  p0_wstrb;
    logic        p0_bvalid, p0_bready, p0_rvalid, p0_rlast, p0_rready;
    logic        p1_arw_valid, p1_arw_ready;
    logic [26:0] p1_arw_addr;
    logic [7:0]  p1_arw_len;
    logic        p1_rvalid, p1_rlast, p1_rready;
    logic [63:0] rdata;
    logic        m_arw_valid, m_arw_ready, m_arw_write;
    logic [26:0] m_arw_addr;
    logic [7:0]  m_arw_len;
    logic [0:0]  m_arw_id;
    logic        m_wvalid, m_wready, m_wlast;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic        m_bvalid, m_bready, m_rvalid, m_rready, m_rlast;
    logic [63:0] m_rdata;

    ddr_port_arbiter #(.ADDR_W(27), .ID_WIDTH(1)) dut (
        .clk(clk), .reset(reset),
        .p0_arw_valid(p0_arw_valid), .p0_arw_ready(p0_arw_ready), .p0_arw_addr(p0_arw_addr),
        .p0_arw_len(p0_arw_len), .p0_arw_write(p0_arw_write),
        .p0_wvalid(p0_wvalid), .p0_wready(p0_wready), .p0_wlast(p0_wlast),
        .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb),
        .p0_bvalid(p0_bvalid), .p0_bready(p0_bready),
        .p0_rvalid(p0_rvalid), .p0_rlast(p0_rlast), .p0_rready(p0_rready),
        .p1_arw_valid(p1_arw_valid), .p1_arw_ready(p1_arw_ready), .p1_arw_addr(p1_arw_addr),
        .p1_arw_len(p1_arw_len),
        .p1_rvalid(p1_rvalid), .p1_rlast(p1_rlast), .p1_rready(p1_rready),
        .rdata(rdata),
        .m_arw_valid(m_arw_valid), .m_arw_ready(m_arw_ready), .m_arw_addr(m_arw_addr),
        .m_arw_len(m_arw_len), .m_arw_write(m_arw_write), .m_arw_id(m_arw_id),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // scoreboards
    logic [36:0] cmdq[$];   // {addr, len, write, id}
    logic [64:0] p0_rq[$];  // {data, last}
    logic [64:0] p1_rq[$];
    logic [72:0] wq[$];     // {data, strb, last}
    int writes_pending = 0;
    int p1_beats = 0;

    // monitor-side reference state
    logic        busy = 1'b0;
    logic        model_last = 1'b1;
    logic        cmd_held = 1'b0;
    logic [36:0] held_val;
    logic        reset_prev = 1'b0;
    logic        first_cmd = 1'b1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got=timeout expected=event at %0t", name, $time);
    endtask

    // Memory contents as seen by the controller model: a fixed function of address and beat.
    function automatic logic [63:0] mem_word(input logic [26:0] a, input int b);
        return {5'd0, a, 32'(b)} ^ 64'hA5A5_0000_0000_5A5A;
    endfunction

    function automatic int beats_of(input logic [7:0] len);
        return 2 * (int'(len) + 1);
    endfunction

    // ---------------- port drivers ----------------
    task automatic p0_txn(input logic wr, input logic [26:0] addr, input logic [7:0] len);
        int guard = 0;
        int nb = beats_of(len);
        @(posedge clk); #1;
        p0_arw_valid = 1'b1; p0_arw_addr = addr; p0_arw_len = len; p0_arw_write = wr;
        forever begin
            @(negedge clk);
            if (p0_arw_ready) break;
            guard++;
            if (guard > 3000) begin fail("p0_accept"); p0_arw_valid = 1'b0; return; end
        end
        cmdq.push_back({addr, len, wr, 1'b0});
        if (wr) writes_pending++;
        else for (int i = 0; i < nb; i++) p0_rq.push_back({mem_word(addr, i), i == nb - 1});
        @(posedge clk); #1;
        p0_arw_valid = 1'b0; p0_arw_addr = 27'($urandom); p0_arw_write = 1'($urandom);
        if (wr) begin
            for (int i = 0; i < nb; i++) begin
                p0_wvalid = 1'b1;
                p0_wdata  = {$urandom, $urandom};
                p0_wstrb  = 8'($urandom);
                p0_wlast  = (i == nb - 1);
                wq.push_back({p0_wdata, p0_wstrb, p0_wlast});
                guard = 0;
                forever begin
                    @(negedge clk);
                    if (p0_wready) break;
                    guard++;
                    if (guard > 3000) begin fail("p0_wbeat"); p0_wvalid = 1'b0; return; end
                end
                @(posedge clk); #1;
            end
            p0_wvalid = 1'b0; p0_wlast = 1'b0;
        end
    endtask

    task automatic p1_txn(input logic [26:0] addr, input logic [7:0] len);
        int guard = 0;
        int nb = beats_of(len);
        @(posedge clk); #1;
        p1_arw_valid = 1'b1; p1_arw_addr = addr; p1_arw_len = len;
        forever begin
            @(negedge clk);
            if (p1_arw_ready) break;
            guard++;
            if (guard > 3000) begin fail("p1_accept"); p1_arw_valid = 1'b0; return; end
        end
        cmdq.push_back({addr, len, 1'b0, 1'b1});
        for (int i = 0; i < nb; i++) p1_rq.push_back({mem_word(addr, i), i == nb - 1});
        @(posedge clk); #1;
        p1_arw_valid = 1'b0; p1_arw_addr = 27'($urandom);
    endtask

    // ---------------- DDR controller model ----------------
    task automatic ctrl_clear();
        m_arw_ready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
        m_rvalid = 1'b0; m_rlast = 1'b0;
    endtask

    task automatic ctrl_serve();
        int stall;
        int guard;
        int nb;
        logic wr;
        logic [26:0] addr;
        @(negedge clk);
        if (reset || !m_arw_valid) return;
        stall = first_cmd ? 5 : $urandom_range(0, 3);
        first_cmd = 1'b0;
        repeat (stall) begin
            @(posedge clk); #1;
            if (reset) begin ctrl_clear(); return; end
        end
        @(posedge clk); #1;
        if (reset) begin ctrl_clear(); return; end
        m_arw_ready = 1'b1;
        @(negedge clk);
        wr = m_arw_write; addr = m_arw_addr; nb = beats_of(m_arw_len);
        @(posedge clk); #1;
        m_arw_ready = 1'b0;
        if (reset) begin ctrl_clear(); return; end
        if (wr) begin
            guard = 0;
            forever begin
                m_wready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (reset) begin ctrl_clear(); return; end
                if (m_wvalid && m_wready && m_wlast) break;
                guard++;
                if (guard > 3000) begin fail("ctrl_wlast"); ctrl_clear(); return; end
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
            m_wready = 1'b0;
            if (reset) begin ctrl_clear(); return; end
            m_bvalid = 1'b1;
            guard = 0;
            forever begin
                @(negedge clk);
                if (reset) begin ctrl_clear(); return; end
                if (m_bready) break;
                guard++;
                if (guard > 3000) begin fail("ctrl_bready"); ctrl_clear(); return; end
            end
            @(posedge clk); #1;
            m_bvalid = 1'b0;
        end else begin
            for (int i = 0; i < nb; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    m_rvalid = 1'b0; m_rlast = 1'b0;
                    @(posedge clk); #1;
                    if (reset) begin ctrl_clear(); return; end
                end
                m_rvalid = 1'b1; m_rdata = mem_word(addr, i); m_rlast = (i == nb - 1);
                @(posedge clk); #1;
                if (reset) begin ctrl_clear(); return; end
            end
            m_rvalid = 1'b0; m_rlast = 1'b0;
        end
    endtask

    initial begin
        ctrl_clear();
        m_rdata = '0;
        forever ctrl_serve();
    end

    // ---------------- monitor / checker ----------------
    logic [1:0]  exp_rdy;
    logic        any_req, win;
    logic [36:0] cur_cmd, exp_cmd;
    logic [64:0] exp_r;
    logic [72:0] exp_w;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                check("reset_handshakes_zero",
                      64'({p0_arw_ready, p1_arw_ready, p0_wready, p0_bvalid, p0_rvalid, p0_rlast,
                           p1_rvalid, p1_rlast, m_arw_valid, m_wvalid, m_wlast, m_bready, m_rready}),
                      64'd0);
                if (reset_prev)
                    check("reset_payload_zero",
                          64'({m_arw_addr, m_arw_len, m_arw_write, m_arw_id}), 64'd0);
                busy = 1'b0; model_last = 1'b1; cmd_held = 1'b0; reset_prev = 1'b1;
            end else begin
                reset_prev = 1'b0;
                // arbitration and one-at-a-time rule
                any_req = p0_arw_valid || p1_arw_valid;
                exp_rdy = 2'b00;
                win = 1'b0;
                if (!busy && any_req) begin
                    win = (p0_arw_valid && p1_arw_valid) ? ~model_last : p1_arw_valid;
                    exp_rdy = win ? 2'b10 : 2'b01;
                end
                check("arw_ready_grant", 64'({p1_arw_ready, p0_arw_ready}), 64'(exp_rdy));
                if (!busy && any_req) begin
                    model_last = win;
                    busy = 1'b1;
                end else if (busy && ((m_bvalid && m_bready) || (m_rvalid && m_rlast))) begin
                    busy = 1'b0;
                end
                // command channel
                if (m_arw_valid) begin
                    cur_cmd = {m_arw_addr, m_arw_len, m_arw_write, m_arw_id};
                    if (cmd_held) check("arw_payload_stable", 64'(cur_cmd), 64'(held_val));
                    if (m_arw_ready) begin
                        if (cmdq.size() == 0) fail("arw_unexpected");
                        else begin
                            exp_cmd = cmdq.pop_front();
                            check("arw_cmd", 64'(cur_cmd), 64'(exp_cmd));
                            $display("txn port=%0d write=%0d addr=%h len=%0d",
                                     m_arw_id, m_arw_write, m_arw_addr, m_arw_len);
                        end
                        cmd_held = 1'b0;
                    end else begin
                        cmd_held = 1'b1;
                        held_val = cur_cmd;
                    end
                end else begin
                    cmd_held = 1'b0;
                end
                // write data
                if (m_wvalid && m_wready) begin
                    if (wq.size() == 0) fail("w_unexpected");
                    else begin
                        exp_w = wq.pop_front();
                        check("w_beat", 64'(m_wdata), exp_w[72:9]);
                        check("w_strb_last", 64'({m_wstrb, m_wlast}), 64'(exp_w[8:0]));
                    end
                end
                // write response
                if (p0_bvalid) begin
                    check("b_mirror", 64'(m_bvalid), 64'd1);
                    if (p0_bready) begin
                        if (writes_pending == 0) fail("b_unexpected");
                        else writes_pending--;
                    end
                end
                // read data, port 0
                if (p0_rvalid) begin
                    if (p0_rq.size() == 0) fail("p0_r_unexpected");
                    else begin
                        exp_r = p0_rq.pop_front();
                        check("p0_rdata", rdata, exp_r[64:1]);
                        check("p0_rlast", 64'(p0_rlast), 64'(exp_r[0]));
                    end
                end
                // read data, port 1
                if (p1_rvalid) begin
                    p1_beats++;
                    if (p1_rq.size() == 0) fail("p1_r_unexpected");
                    else begin
                        exp_r = p1_rq.pop_front();
                        check("p1_rdata", rdata, exp_r[64:1]);
                        check("p1_rlast", 64'(p1_rlast), 64'(exp_r[0]));
                    end
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog: got=running expected=finished at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_drained(input string name);
        int guard = 0;
        while (busy || cmdq.size() != 0 || p0_rq.size() != 0 || p1_rq.size() != 0 ||
               wq.size() != 0 || writes_pending != 0) begin
            @(negedge clk);
            guard++;
            if (guard > 3000) begin fail(name); return; end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int guard;
        int start_beats;
        reset = 1'b1;
        p0_arw_valid = 1'b1; p0_arw_addr = 27'h55; p0_arw_len = 8'd2; p0_arw_write = 1'b0;
        p0_wvalid = 1'b0; p0_wlast = 1'b0; p0_wdata = '0; p0_wstrb = '0;
        p0_bready = 1'b1; p0_rready = 1'b1;
        p1_arw_valid = 1'b1; p1_arw_addr = 27'h66; p1_arw_len = 8'd1; p1_rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        p0_arw_valid = 1'b0; p1_arw_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        // Both ports start with a read in the same cycle; port 0 then does the
        // 0x100 write, afterwards everything is random.
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    if (i == 0)      p0_txn(1'b0, 27'h200, 8'd1);
                    else if (i == 1) p0_txn(1'b1, 27'h100, 8'd1);
                    else p0_txn(1'($urandom), 27'($urandom), 8'($urandom_range(0, 3)));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                end
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    p1_txn(27'($urandom), 8'($urandom_range(0, 3)));
                    if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
                end
            end
        join
        wait_drained("drain_random");

        // Reset in the middle of a port 1 burst, then a fresh port 1 read.
        start_beats = p1_beats;
        p1_txn(27'h3A0, 8'd3);
        guard = 0;
        while (p1_beats < start_beats + 3) begin
            @(negedge clk);
            guard++;
            if (guard > 3000) begin fail("p1_burst_start"); break; end
        end
        @(posedge clk); #1;
        reset = 1'b1;
        p1_rq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_idle",
              64'({p0_arw_ready, p1_arw_ready, p0_wready, p0_bvalid, p0_rvalid, p0_rlast,
                   p1_rvalid, p1_rlast, m_arw_valid, m_wvalid, m_wlast, m_bready, m_rready}),
              64'd0);
        start_beats = p1_beats;
        p1_txn(27'h4C0, 8'd1);
        wait_drained("drain_after_reset");
        check("p1_fresh_beats", 64'(p1_beats - start_beats), 64'd4);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
